multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Next-generation main control for the MIPS datapath: replaces the single-cycle opcode decoder with a multicycle control FSM.
- Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK per instruction and stalls on a memory ready handshake.
- Holds EXECUTE for a parametrised number of cycles on multiply.
- Covers R-type (and/or/add/sub/mul), addi, lw, sw, beq and j; drives the shared PC/IR/register-file/ALU/memory datapath.

Parameters:
- MUL_CYCLES, 4, cycles spent in EXEC for R-type mul (1..15); 1 means same timing as other R-type.
- MUL_FUNCT, 6'b011000, funct value identifying mul.
- CNT_W, 4, width of the internal multiply counter; must satisfy 2**CNT_W > MUL_CYCLES.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-high reset.
- Op_i  input  6  opcode from IR.
- Funct_i  input  6  funct field from IR.
- mem_ready_i  input  1  memory has completed the current access this cycle.
- PCWrite_o  output  1  unconditional PC write.
- PCWriteCond_o  output  1  PC write if ALU zero (beq).
- IorD_o  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead_o  output  1  memory read request.
- MemWrite_o  output  1  memory write request.
- IRWrite_o  output  1  IR load.
- MemtoReg_o  output  1  write-back data select: 1 = MDR, 0 = ALUOut.
- RegDst_o  output  1  1 = rd, 0 = rt.
- RegWrite_o  output  1  register file write.
- ALUSrcA_o  output  1  0 = PC, 1 = rs.
- ALUSrcB_o  output  2  00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- ALUOp_o  output  2  00 = add, 01 = sub, 11 = R-type funct decode.
- PCSource_o  output  2  00 = ALU, 01 = ALUOut, 10 = jump target.
- mul_busy_o  output  1  high while a mul occupies EXEC.
- illegal_o  output  1  one-cycle pulse in DECODE on an unsupported opcode.

Behaviour:
- Reset (async, rst_i=1):
  - State goes to FETCH and the mul counter clears to 0.
  - While rst_i is high, every output is 0, including MemRead_o.
  - After deassertion, outputs are decoded from state.
- All outputs are combinational from state, except the FETCH and MEMREAD/MEMWRITE gates on mem_ready_i described below.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite equal mem_ready_i.
  - Stay while mem_ready_i=0; go to DECODE on mem_ready_i=1.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - Next state by Op_i:
    - 000000 goes to EXEC.
    - 001000 goes to ADDI_EX.
    - 100011 and 101011 go to MEMADDR.
    - 000100 goes to BRANCH.
    - 000010 goes to JUMP.
    - Any other opcode pulses illegal_o and returns to FETCH (no architectural write).
- EXEC:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=11.
  - If Funct_i==MUL_FUNCT: counter increments each cycle and mul_busy_o=1. Leave for RWB when counter==MUL_CYCLES-1, clearing the counter.
  - Otherwise leave after 1 cycle.
- RWB: RegDst=1, MemtoReg=0, RegWrite=1; then FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; then ADDI_WB.
- ADDI_WB: RegDst=0, MemtoReg=0, RegWrite=1; then FETCH.
- MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; lw goes to MEMREAD, sw goes to MEMWRITE.
- MEMREAD: MemRead=1, IorD=1; hold until mem_ready_i, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; then FETCH.
- MEMWRITE: MemWrite=1, IorD=1; hold until mem_ready_i, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; then FETCH.
- JUMP: PCWrite=1, PCSource=10; then FETCH.
- Unlisted outputs are 0 in every state.
- Cycle counts with mem_ready_i always 1:
  - beq and j: 3.
  - R-type non-mul and addi: 4.
  - sw: 4.
  - lw: 5.
  - mul: 3+MUL_CYCLES.
- Op_i and Funct_i are sampled from the IR and are stable after FETCH; the FSM only reads them in DECODE, EXEC and MEMADDR.
- Reset mid-operation (any state, including mid-mul or a memory wait) aborts immediately to FETCH with the counter at 0; no write enable glitches high.
- Unreachable state encodings recover to FETCH.

Decomposition:
- Shared package mips_ctrl_pkg:
  - Opcode constants: OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J.
  - ALUOp encodings.
  - ALUSrcB and PCSource encodings.
  - State enum typedef.
- The package is reused by the existing ALU control.
- One sub-module: mul_latency_counter (enable, clear, done at MUL_CYCLES-1, async reset).

Test Plan:
- Reset: rst_i=1 mid-run → all outputs 0 immediately. Release with mem_ready_i=1 → FETCH asserts MemRead=1, IRWrite=1, PCWrite=1 on the first edge.
- add (Op=000000, Funct=100000), mem_ready=1 → RegWrite=1 and RegDst=1 exactly in cycle 4; FETCH again in cycle 5.
- mul (Funct=011000), MUL_CYCLES=4:
  - mul_busy_o high for 4 cycles and RegWrite in cycle 7.
  - Rerun with MUL_CYCLES=1 → RegWrite in cycle 4.
- lw (Op=100011) with mem_ready low for 2 cycles in FETCH and 3 in MEMREAD:
  - IRWrite only on the ready cycle.
  - MemtoReg=1 with RegWrite=1 in cycle 10.
- beq (000100) → PCWriteCond=1, ALUOp=01, PCSource=01 in cycle 3. j (000010) → PCWrite=1, PCSource=10 in cycle 3.
- Op=111111 → illegal_o pulses 1 cycle in DECODE, no write enables, back to FETCH. rst_i asserted in EXEC cycle 2 of a mul → mul_busy_o drops, counter 0 on restart.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control definitions: opcodes, datapath select encodings and the
// multicycle FSM state type. Also used by the ALU control block.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b11;

   localparam logic [1:0] SRCB_RT   = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_BR   = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC, S_RWB, S_ADDI_EX, S_ADDI_WB,
      S_MEMADDR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_BRANCH, S_JUMP
   } state_t;

   function automatic logic is_legal_op(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
             (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
   endfunction

endpackage

// File: rtl/mul_latency_counter.sv
// Counts cycles a multiply has spent in EXEC; done marks the final cycle.
module mul_latency_counter
   import mips_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = 4,
   parameter int CNT_W      = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic clr_i,
   output logic done_o
);

   logic [CNT_W-1:0] r_cnt;

   assign done_o = (r_cnt == CNT_W'(MUL_CYCLES - 1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         r_cnt <= '0;
      else if (clr_i)
         r_cnt <= '0;
      else if (en_i)
         r_cnt <= r_cnt + CNT_W'(1);
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory ready stalls and a multi-cycle EXEC hold for mul.
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int         MUL_CYCLES = 4,
   parameter logic [5:0] MUL_FUNCT  = 6'b011000,
   parameter int         CNT_W      = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [5:0] Op_i,
   input  logic [5:0] Funct_i,
   input  logic       mem_ready_i,
   output logic       PCWrite_o,
   output logic       PCWriteCond_o,
   output logic       IorD_o,
   output logic       MemRead_o,
   output logic       MemWrite_o,
   output logic       IRWrite_o,
   output logic       MemtoReg_o,
   output logic       RegDst_o,
   output logic       RegWrite_o,
   output logic       ALUSrcA_o,
   output logic [1:0] ALUSrcB_o,
   output logic [1:0] ALUOp_o,
   output logic [1:0] PCSource_o,
   output logic       mul_busy_o,
   output logic       illegal_o
);

   state_t r_state;
   logic   w_is_mul;
   logic   w_mul_en;
   logic   w_mul_done;

   assign w_is_mul = (Funct_i == MUL_FUNCT);
   assign w_mul_en = (r_state == S_EXEC) && w_is_mul;

   mul_latency_counter #(
      .MUL_CYCLES (MUL_CYCLES),
      .CNT_W      (CNT_W)
   ) u_mul_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (w_mul_en),
      .clr_i  (w_mul_en && w_mul_done),
      .done_o (w_mul_done)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_FETCH;
      end else begin
         case (r_state)
            S_FETCH:    if (mem_ready_i) r_state <= S_DECODE;
            S_DECODE: begin
               case (Op_i)
                  OP_RTYPE:     r_state <= S_EXEC;
                  OP_ADDI:      r_state <= S_ADDI_EX;
                  OP_LW, OP_SW: r_state <= S_MEMADDR;
                  OP_BEQ:       r_state <= S_BRANCH;
                  OP_J:         r_state <= S_JUMP;
                  default:      r_state <= S_FETCH;
               endcase
            end
            S_EXEC:     if (!w_is_mul || w_mul_done) r_state <= S_RWB;
            S_ADDI_EX:  r_state <= S_ADDI_WB;
            S_MEMADDR:  r_state <= (Op_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready_i) r_state <= S_MEMWB;
            S_MEMWRITE: if (mem_ready_i) r_state <= S_FETCH;
            default:    r_state <= S_FETCH;
         endcase
      end
   end

   // Outputs are forced low for the whole reset window, not just after the edge.
   always_comb begin
      PCWrite_o     = 1'b0;
      PCWriteCond_o = 1'b0;
      IorD_o        = 1'b0;
      MemRead_o     = 1'b0;
      MemWrite_o    = 1'b0;
      IRWrite_o     = 1'b0;
      MemtoReg_o    = 1'b0;
      RegDst_o      = 1'b0;
      RegWrite_o    = 1'b0;
      ALUSrcA_o     = 1'b0;
      ALUSrcB_o     = SRCB_RT;
      ALUOp_o       = ALUOP_ADD;
      PCSource_o    = PCSRC_ALU;
      mul_busy_o    = 1'b0;
      illegal_o     = 1'b0;
      if (!rst_i) begin
         case (r_state)
            S_FETCH: begin
               MemRead_o = 1'b1;
               ALUSrcB_o = SRCB_FOUR;
               IRWrite_o = mem_ready_i;
               PCWrite_o = mem_ready_i;
            end
            S_DECODE: begin
               ALUSrcB_o = SRCB_BR;
               illegal_o = !is_legal_op(Op_i);
            end
            S_EXEC: begin
               ALUSrcA_o  = 1'b1;
               ALUOp_o    = ALUOP_FUNCT;
               mul_busy_o = w_is_mul;
            end
            S_RWB: begin
               RegDst_o   = 1'b1;
               RegWrite_o = 1'b1;
            end
            S_ADDI_EX, S_MEMADDR: begin
               ALUSrcA_o = 1'b1;
               ALUSrcB_o = SRCB_IMM;
            end
            S_ADDI_WB:  RegWrite_o = 1'b1;
            S_MEMREAD: begin
               MemRead_o = 1'b1;
               IorD_o    = 1'b1;
            end
            S_MEMWB: begin
               MemtoReg_o = 1'b1;
               RegWrite_o = 1'b1;
            end
            S_MEMWRITE: begin
               MemWrite_o = 1'b1;
               IorD_o     = 1'b1;
            end
            S_BRANCH: begin
               ALUSrcA_o     = 1'b1;
               ALUOp_o       = ALUOP_SUB;
               PCWriteCond_o = 1'b1;
               PCSource_o    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
               PCWrite_o  = 1'b1;
               PCSource_o = PCSRC_JUMP;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction is expanded into its
// expected per-cycle control words and compared against two DUTs (MUL_CYCLES 4 and 1).
module tb_multicycle_control;

   typedef struct packed {
      logic       pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca;
      logic [1:0] srcb, aluop, pcsrc;
      logic       busy, ill;
   } cw_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] op;
   logic [5:0] funct;
   logic       rdy;
   logic       sel;
   cw_t        cw_a, cw_b, cw_obs;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   multicycle_control #(.MUL_CYCLES(4)) u_dut_a (
      .clk_i(clk), .rst_i(rst), .Op_i(op), .Funct_i(funct), .mem_ready_i(rdy),
      .PCWrite_o(cw_a.pcw), .PCWriteCond_o(cw_a.pcwc), .IorD_o(cw_a.iord),
      .MemRead_o(cw_a.mr), .MemWrite_o(cw_a.mw), .IRWrite_o(cw_a.irw),
      .MemtoReg_o(cw_a.m2r), .RegDst_o(cw_a.rdst), .RegWrite_o(cw_a.rw),
      .ALUSrcA_o(cw_a.srca), .ALUSrcB_o(cw_a.srcb), .ALUOp_o(cw_a.aluop),
      .PCSource_o(cw_a.pcsrc), .mul_busy_o(cw_a.busy), .illegal_o(cw_a.ill)
   );

   multicycle_control #(.MUL_CYCLES(1)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .Op_i(op), .Funct_i(funct), .mem_ready_i(rdy),
      .PCWrite_o(cw_b.pcw), .PCWriteCond_o(cw_b.pcwc), .IorD_o(cw_b.iord),
      .MemRead_o(cw_b.mr), .MemWrite_o(cw_b.mw), .IRWrite_o(cw_b.irw),
      .MemtoReg_o(cw_b.m2r), .RegDst_o(cw_b.rdst), .RegWrite_o(cw_b.rw),
      .ALUSrcA_o(cw_b.srca), .ALUSrcB_o(cw_b.srcb), .ALUOp_o(cw_b.aluop),
      .PCSource_o(cw_b.pcsrc), .mul_busy_o(cw_b.busy), .illegal_o(cw_b.ill)
   );

   assign cw_obs = sel ? cw_b : cw_a;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   cw_t  exp_q[$];
   logic rdy_q[$];

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Expected control words for one instruction, FETCH through its final state.
   task automatic build(input logic [5:0] o, input logic [5:0] f, input int nf, input int nm);
      cw_t c;
      int  mc;
      bit  legal;
      mc = sel ? 1 : 4;
      legal = (o == 6'b000000) || (o == 6'b001000) || (o == 6'b100011) ||
              (o == 6'b101011) || (o == 6'b000100) || (o == 6'b000010);
      exp_q.delete();
      rdy_q.delete();
      c = '0; c.mr = 1; c.srcb = 2'b01;
      for (int i = 0; i < nf; i++) begin exp_q.push_back(c); rdy_q.push_back(1'b0); end
      c.irw = 1; c.pcw = 1;
      exp_q.push_back(c); rdy_q.push_back(1'b1);
      c = '0; c.srcb = 2'b11; c.ill = !legal;
      exp_q.push_back(c); rdy_q.push_back(rnd_bit());
      c = '0;
      if (o == 6'b000000) begin
         c.srca = 1; c.aluop = 2'b11;
         if (f == 6'b011000) begin
            c.busy = 1;
            for (int i = 0; i < mc; i++) begin exp_q.push_back(c); rdy_q.push_back(rnd_bit()); end
         end else begin
            exp_q.push_back(c); rdy_q.push_back(rnd_bit());
         end
         c = '0; c.rdst = 1; c.rw = 1;
         exp_q.push_back(c); rdy_q.push_back(rnd_bit());
      end else if (o == 6'b001000) begin
         c.srca = 1; c.srcb = 2'b10;
         exp_q.push_back(c); rdy_q.push_back(rnd_bit());
         c = '0; c.rw = 1;
         exp_q.push_back(c); rdy_q.push_back(rnd_bit());
      end else if (o == 6'b100011 || o == 6'b101011) begin
         c.srca = 1; c.srcb = 2'b10;
         exp_q.push_back(c); rdy_q.push_back(rnd_bit());
         c = '0; c.iord = 1;
         if (o == 6'b100011) c.mr = 1; else c.mw = 1;
         for (int i = 0; i < nm; i++) begin exp_q.push_back(c); rdy_q.push_back(1'b0); end
         exp_q.push_back(c); rdy_q.push_back(1'b1);
         if (o == 6'b100011) begin
            c = '0; c.m2r = 1; c.rw = 1;
            exp_q.push_back(c); rdy_q.push_back(rnd_bit());
         end
      end else if (o == 6'b000100) begin
         c.srca = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01;
         exp_q.push_back(c); rdy_q.push_back(rnd_bit());
      end else if (o == 6'b000010) begin
         c.pcw = 1; c.pcsrc = 2'b10;
         exp_q.push_back(c); rdy_q.push_back(rnd_bit());
      end
   endtask

   // Entered and left at #1 after a rising edge; limit truncates the instruction.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                            input int nf, input int nm, input int limit);
      build(o, f, nf, nm);
      op = o;
      funct = f;
      for (int i = 0; i < exp_q.size() && i < limit; i++) begin
         rdy = rdy_q[i];
         #1;
         check_eq($sformatf("op%b_f%b_c%0d", o, f, i + 1), 32'(cw_obs), 32'(exp_q[i]));
         @(posedge clk);
         #1;
      end
   endtask

   logic [5:0] op_tbl [9]    = '{6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100,
                                 6'b000010, 6'b111111, 6'b000011, 6'b100000};
   logic [5:0] funct_tbl [5] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b011000};

   task automatic run_random(input int n);
      logic [5:0] o, f;
      for (int k = 0; k < n; k++) begin
         o = op_tbl[$urandom_range(0, 8)];
         f = funct_tbl[$urandom_range(0, 4)];
         run_instr(o, f, $urandom_range(0, 2), $urandom_range(0, 3), 1000);
      end
   endtask

   initial begin
      rst = 1'b1; op = '0; funct = '0; rdy = 1'b0; sel = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_outputs", 32'(cw_obs), 32'(0));
      rst = 1'b0;

      run_instr(6'b000000, 6'b100000, 0, 0, 1000);  // add
      run_instr(6'b000000, 6'b011000, 0, 0, 1000);  // mul
      run_instr(6'b100011, 6'b000000, 2, 3, 1000);  // lw with stalls
      run_instr(6'b101011, 6'b000000, 1, 2, 1000);  // sw with stalls
      run_instr(6'b000100, 6'b000000, 0, 0, 1000);  // beq
      run_instr(6'b000010, 6'b000000, 0, 0, 1000);  // j
      run_instr(6'b111111, 6'b000000, 0, 0, 1000);  // illegal
      run_instr(6'b001000, 6'b000000, 0, 0, 1000);  // addi

      // Reset in the second EXEC cycle of a mul, held over an edge.
      run_instr(6'b000000, 6'b011000, 0, 0, 3);
      rst = 1'b1;
      #1;
      check_eq("rst_mid_mul", 32'(cw_obs), 32'(0));
      @(posedge clk);
      #1;
      check_eq("rst_held", 32'(cw_obs), 32'(0));
      rst = 1'b0;
      run_instr(6'b000000, 6'b011000, 0, 0, 1000);

      run_random(60);

      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sel = 1'b1;
      run_instr(6'b000000, 6'b011000, 0, 0, 1000);
      run_instr(6'b000000, 6'b100010, 0, 0, 1000);
      run_random(25);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
